// File: rtl/outport.sv
// Dual-digit seven-segment output port: each channel latches a nibble under
// its own strobe and drives the registered hex segment pattern for it.

module outport_channel #(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data,
   input  logic       load,
   output logic [6:0] seg
);

   localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h7E;
         4'h1:    pat = 7'h30;
         4'h2:    pat = 7'h6D;
         4'h3:    pat = 7'h79;
         4'h4:    pat = 7'h33;
         4'h5:    pat = 7'h5B;
         4'h6:    pat = 7'h5F;
         4'h7:    pat = 7'h70;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h7B;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h1F;
         4'hC:    pat = 7'h4E;
         4'hD:    pat = 7'h3D;
         4'hE:    pat = 7'h4F;
         4'hF:    pat = 7'h47;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   function automatic logic [6:0] apply_polarity(input logic [6:0] pat);
      return SEG_ACTIVE_LOW ? ~pat : pat;
   endfunction

   logic [3:0] nib_r;
   logic       valid_r;
   logic [3:0] nib_next_s;
   logic       valid_next_s;
   logic [6:0] seg_next_s;

   // Next-state selection; on hold the output is rebuilt from the stored
   // nibble so an upset in the output register is scrubbed on the next edge.
   always_comb begin
      nib_next_s   = nib_r;
      valid_next_s = valid_r;
      seg_next_s   = BLANK;
      if (load) begin
         nib_next_s   = data;
         valid_next_s = 1'b1;
      end else begin
         nib_next_s   = nib_r;
         valid_next_s = valid_r;
      end
      if (valid_next_s) begin
         seg_next_s = apply_polarity(seg_decode(nib_next_s));
      end else begin
         seg_next_s = BLANK;
      end
   end

   // Channel state and registered segment output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nib_r   <= 4'h0;
         valid_r <= 1'b0;
         seg     <= BLANK;
      end else begin
         nib_r   <= nib_next_s;
         valid_r <= valid_next_s;
         seg     <= seg_next_s;
      end
   end

endmodule

module outport #(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ind1,
   input  logic [3:0] ind2,
   input  logic       Reg1CR,
   input  logic       Reg2CR,
   output logic [6:0] Reg1_out,
   output logic [6:0] Reg2_out
);

   outport_channel #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_digit1 (
      .clk  (clk),
      .rst  (rst),
      .data (ind1),
      .load (Reg1CR),
      .seg  (Reg1_out)
   );

   outport_channel #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_digit2 (
      .clk  (clk),
      .rst  (rst),
      .data (ind2),
      .load (Reg2CR),
      .seg  (Reg2_out)
   );

endmodule

// File: tb/tb_outport.sv
// Bench for outport: both polarities side by side, checked every cycle against
// a table-lookup model, plus hand-computed literal expectations.

module tb_outport;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] ind1 = 4'h0;
   logic [3:0] ind2 = 4'h0;
   logic       Reg1CR = 1'b0;
   logic       Reg2CR = 1'b0;
   logic [6:0] r1_h, r2_h, r1_l, r2_l;

   always #5 clk = ~clk;

   outport #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .ind1(ind1), .ind2(ind2),
      .Reg1CR(Reg1CR), .Reg2CR(Reg2CR), .Reg1_out(r1_h), .Reg2_out(r2_h)
   );

   outport #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .ind1(ind1), .ind2(ind2),
      .Reg1CR(Reg1CR), .Reg2CR(Reg2CR), .Reg1_out(r1_l), .Reg2_out(r2_l)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16];
   logic [3:0] m_nib    [2];
   logic       m_loaded [2];

   initial begin
      seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
      m_nib    = '{4'h0, 4'h0};
      m_loaded = '{1'b0, 1'b0};
   end

   // Model: a digit shows the last nibble it was strobed with, blank until then.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_loaded[0] <= 1'b0;
         m_loaded[1] <= 1'b0;
      end else begin
         if (Reg1CR) begin
            m_nib[0]    <= ind1;
            m_loaded[0] <= 1'b1;
         end
         if (Reg2CR) begin
            m_nib[1]    <= ind2;
            m_loaded[1] <= 1'b1;
         end
      end
   end

   function automatic logic [6:0] expect_seg(input int ch, input bit al);
      logic [6:0] v;
      v = m_loaded[ch] ? seg_tab[m_nib[ch]] : 7'h00;
      return al ? ~v : v;
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of all four outputs against the model.
   always @(negedge clk) begin
      check("model_d1_hi", r1_h, expect_seg(0, 1'b0));
      check("model_d2_hi", r2_h, expect_seg(1, 1'b0));
      check("model_d1_lo", r1_l, expect_seg(0, 1'b1));
      check("model_d2_lo", r2_l, expect_seg(1, 1'b1));
   end

   task automatic check_all_now(input string name);
      check({name, "_d1_hi"}, r1_h, expect_seg(0, 1'b0));
      check({name, "_d2_hi"}, r2_h, expect_seg(1, 1'b0));
      check({name, "_d1_lo"}, r1_l, expect_seg(0, 1'b1));
      check({name, "_d2_lo"}, r2_l, expect_seg(1, 1'b1));
   endtask

   initial begin
      // Reset held with strobes active: everything stays blank.
      #2 rst = 1'b0;
      Reg1CR = 1'b1; Reg2CR = 1'b1; ind1 = 4'h4; ind2 = 4'h8;
      repeat (4) @(negedge clk);
      check("rst_d1_hi", r1_h, 7'h00);
      check("rst_d2_hi", r2_h, 7'h00);
      check("rst_d1_lo", r1_l, 7'h7F);

      // Release with strobes high: one edge loads 4/8.
      #1 rst = 1'b1;
      @(negedge clk);
      check("load_d1_hi", r1_h, 7'h33);
      check("load_d2_hi", r2_h, 7'h7F);
      check("load_d1_lo", r1_l, 7'h4C);
      check("load_d2_lo", r2_l, 7'h00);

      // Hold: data changes without strobes have no effect.
      #1 Reg1CR = 1'b0; Reg2CR = 1'b0; ind1 = 4'hF; ind2 = 4'h0;
      repeat (3) @(negedge clk);
      check("hold_d1_hi", r1_h, 7'h33);
      check("hold_d2_hi", r2_h, 7'h7F);

      // Independent channel load.
      #1 Reg1CR = 1'b1; ind1 = 4'hA; ind2 = 4'h3;
      @(negedge clk);
      check("indep_d1_hi", r1_h, 7'h77);
      check("indep_d2_hi", r2_h, 7'h7F);

      // Strobe held high, digit 1 sweeps every code.
      for (int i = 0; i < 16; i++) begin
         #1 ind1 = 4'(i);
         @(negedge clk);
         check("sweep_d1_hi", r1_h, seg_tab[i]);
         check("sweep_d1_lo", r1_l, ~seg_tab[i]);
      end
      check("sweep_last", r1_h, 7'h47);

      // Asynchronous reset between edges blanks outputs without a clock.
      #1 Reg1CR = 1'b1; Reg2CR = 1'b1; ind1 = 4'h4; ind2 = 4'h8;
      @(negedge clk);
      #1 Reg1CR = 1'b0; Reg2CR = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_d1_hi", r1_h, 7'h00);
      check("async_d2_hi", r2_h, 7'h00);
      check("async_d1_lo", r1_l, 7'h7F);
      check("async_d2_lo", r2_l, 7'h7F);
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_d1", r1_h, 7'h00);
      check("post_rst_d2", r2_h, 7'h00);

      // Active-low variant: code 8 lights every segment, i.e. all zeros.
      #1 Reg1CR = 1'b1; ind1 = 4'h8;
      @(negedge clk);
      check("al_eight", r1_l, 7'h00);

      // Randomized traffic with occasional mid-cycle reset pulses.
      for (int n = 0; n < 400; n++) begin
         #1;
         Reg1CR = 1'($urandom_range(0, 1));
         Reg2CR = 1'($urandom_range(0, 1));
         ind1   = 4'($urandom_range(0, 15));
         ind2   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 24) == 0) begin
            @(posedge clk);
            #2 rst = 1'b0;
            #1 check_all_now("rnd_async");
            @(negedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
         end else begin
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/outport.md
Name: outport

Overview:
- Dual-digit output port of the 8-bit RISC processor.
- Each channel latches a 4-bit nibble from the datapath under its own load strobe and drives a 7-segment hex pattern for that nibble.
- Channels are fully independent, share one clock and reset, and drive the board's two seven-segment digits.

Parameters:
- SEG_ACTIVE_LOW, default 0: 0 = segment on is 1 (common cathode); 1 = every output bit inverted, including the blank pattern (common anode).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ind1  input  4  data nibble for digit 1.
- ind2  input  4  data nibble for digit 2.
- Reg1CR  input  1  load strobe, digit 1; active high, sampled on clk rising edge.
- Reg2CR  input  1  load strobe, digit 2; active high, sampled on clk rising edge.
- Reg1_out  output  7  segment pattern for digit 1, bit6..bit0 = a,b,c,d,e,f,g.
- Reg2_out  output  7  segment pattern for digit 2, same bit order.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset state: while rst=0, regardless of clk:
  - stored nibbles = 0.
  - per-channel valid flags = 0.
  - both outputs = blank: 7'h00, or 7'h7F when SEG_ACTIVE_LOW=1.
- Reset takes effect immediately on assertion, including mid-operation. Strobes are ignored while rst=0.
- Load: on a rising edge with rst=1 and RegnCR=1:
  - stored nibble n <= indn.
  - valid flag n <= 1.
  - Regn_out <= decode(indn).
  - Latency: the output reflects the new value right after that same edge (registered output, one-edge latency from strobe sample).
- Hold: with RegnCR=0, the nibble and Regn_out keep their value indefinitely. Changes on indn without a strobe have no effect.
- Strobe held high: the channel reloads every edge and tracks indn with one-edge latency.
- Independence: both strobes high in the same cycle load both channels. One strobe high leaves the other channel untouched.
- After reset release, a channel stays blank until its first load.
- Decode table, active-high, hex digit -> a..g:
  - 0->7E, 1->30, 2->6D, 3->79
  - 4->33, 5->5B, 6->5F, 7->70
  - 8->7F, 9->7B, A->77, b->1F
  - C->4E, d->3D, E->4F, F->47
- SEG_ACTIVE_LOW=1: the output is the bitwise inverse of the table value.
- No X propagation: all 16 codes are defined, and outputs are never undefined after reset.
- Purely synchronous datapath apart from the asynchronous reset. No combinational path from inputs to outputs.

Test Plan:
- Reset: rst=0, strobes=1, ind1=4, ind2=8 over several edges -> Reg1_out=Reg2_out=00 throughout.
- Basic load: release rst, then ind1=4, ind2=8, Reg1CR=Reg2CR=1 for one edge -> Reg1_out=33, Reg2_out=7F after that edge. Then drop strobes and change ind1=F, ind2=0 -> outputs stay 33/7F.
- Independent channels: Reg1CR=1, Reg2CR=0, ind1=A, ind2=3 -> Reg1_out=77, Reg2_out unchanged.
- Full decode sweep: strobe held high, ind1 stepping 0..F one per edge -> Reg1_out follows the table one edge later: 7E,30,6D,...,47.
- Async reset mid-operation: outputs showing 33/7F, assert rst=0 between clock edges -> both outputs 00 immediately without a clock edge. Release -> both stay 00 until the next strobe.
- Polarity variant: SEG_ACTIVE_LOW=1, load ind1=8 -> Reg1_out=00. Reset -> 7F (blank).
